// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and encodings for the pipeline hazard scoreboard
package pipe_pkg;

    localparam int PKG_TNEW_W = 2;
    localparam int PKG_SRC_W  = 3;

    localparam logic [PKG_TNEW_W-1:0] TUSE_NONE = '1;

    typedef enum logic [PKG_SRC_W-1:0] {
        SRC_ALU  = 3'd0,
        SRC_MEM  = 3'd1,
        SRC_PC8  = 3'd2,
        SRC_CP0  = 3'd3,
        SRC_HILO = 3'd4
    } src_e;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [4:0]            dst;
        logic [PKG_TNEW_W-1:0] tnew;
        logic [PKG_SRC_W-1:0]  src;
    } slot_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - D-stage issue/query bundle and scoreboard results
interface hazard_scoreboard_if #(
    parameter int STAGES = 3,
    parameter int TNEW_W = 2,
    parameter int SRC_W  = 3,
    parameter int SEL_W  = $clog2(STAGES + 1)
);
    logic                       issue_valid;
    logic                       issue_we;
    logic [4:0]                 issue_dst;
    logic [TNEW_W-1:0]          issue_tnew;
    logic [SRC_W-1:0]           issue_src;
    logic [4:0]                 rs;
    logic [4:0]                 rt;
    logic [TNEW_W-1:0]          tuse_rs;
    logic [TNEW_W-1:0]          tuse_rt;
    logic                       hold;
    logic                       flush;
    logic                       stall;
    logic [SEL_W-1:0]           fwd_sel_rs;
    logic [SEL_W-1:0]           fwd_sel_rt;
    logic [STAGES*SRC_W-1:0]    slot_src;
    logic [STAGES*TNEW_W-1:0]   slot_tnew;

    modport master (
        output issue_valid, issue_we, issue_dst, issue_tnew, issue_src,
        output rs, rt, tuse_rs, tuse_rt, hold, flush,
        input  stall, fwd_sel_rs, fwd_sel_rt, slot_src, slot_tnew
    );

    modport slave (
        input  issue_valid, issue_we, issue_dst, issue_tnew, issue_src,
        input  rs, rt, tuse_rs, tuse_rt, hold, flush,
        output stall, fwd_sel_rs, fwd_sel_rt, slot_src, slot_tnew
    );
endinterface

// File: rtl/sb_match.sv
// rtl/sb_match.sv - youngest-first priority match of one source register over the slots
module sb_match
    import pipe_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int SEL_W  = $clog2(STAGES + 1)
) (
    input  slot_t                 slots [STAGES],
    input  logic [4:0]            src_reg,
    output logic                  hit,
    output logic [SEL_W-1:0]      idx,
    output logic [PKG_TNEW_W-1:0] tnew
);

    // Scan oldest to youngest so the lowest-index live match is left standing.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        tnew = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (slots[i].valid && slots[i].we && (slots[i].dst != 5'd0) &&
                (slots[i].dst == src_reg)) begin
                hit  = 1'b1;
                idx  = SEL_W'(i);
                tnew = slots[i].tnew;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - Tnew/Tuse scoreboard producing D-stage stall and forward selects
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int TNEW_W = PKG_TNEW_W,
    parameter int SRC_W  = PKG_SRC_W,
    parameter int SEL_W  = $clog2(STAGES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    hazard_scoreboard_if.slave sb
);

    slot_t                 slots [STAGES];
    logic                  hit_rs, hit_rt;
    logic [SEL_W-1:0]      idx_rs, idx_rt;
    logic [PKG_TNEW_W-1:0] tnew_rs, tnew_rt;
    logic                  stall_rs, stall_rt;

    sb_match #(.STAGES(STAGES), .SEL_W(SEL_W)) u_match_rs (
        .slots(slots), .src_reg(sb.rs), .hit(hit_rs), .idx(idx_rs), .tnew(tnew_rs)
    );

    sb_match #(.STAGES(STAGES), .SEL_W(SEL_W)) u_match_rt (
        .slots(slots), .src_reg(sb.rt), .hit(hit_rt), .idx(idx_rt), .tnew(tnew_rt)
    );

    assign stall_rs = hit_rs && (sb.tuse_rs != TUSE_NONE) && (tnew_rs > sb.tuse_rs);
    assign stall_rt = hit_rt && (sb.tuse_rt != TUSE_NONE) && (tnew_rt > sb.tuse_rt);
    assign sb.stall = sb.hold | stall_rs | stall_rt;

    assign sb.fwd_sel_rs = (hit_rs && (tnew_rs == '0)) ? idx_rs + SEL_W'(1) : '0;
    assign sb.fwd_sel_rt = (hit_rt && (tnew_rt == '0)) ? idx_rt + SEL_W'(1) : '0;

    for (genvar g = 0; g < STAGES; g++) begin : g_flat
        assign sb.slot_src[g*SRC_W +: SRC_W]    = slots[g].src;
        assign sb.slot_tnew[g*TNEW_W +: TNEW_W] = slots[g].tnew;
    end

    // Flush only clears valid bits; it takes priority over hold and drops the issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) slots[i] <= '0;
        end else if (sb.flush) begin
            for (int i = 0; i < STAGES; i++) slots[i].valid <= 1'b0;
        end else if (!sb.hold) begin
            for (int i = 1; i < STAGES; i++) begin
                slots[i]      <= slots[i-1];
                slots[i].tnew <= (slots[i-1].tnew != '0) ? slots[i-1].tnew - 1'b1 : '0;
            end
            if (sb.issue_valid && !sb.stall) begin
                slots[0].valid <= 1'b1;
                slots[0].we    <= sb.issue_we && (sb.issue_dst != 5'd0);
                slots[0].dst   <= sb.issue_dst;
                slots[0].tnew  <= sb.issue_tnew;
                slots[0].src   <= sb.issue_src;
            end else begin
                slots[0] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.STAGES(3), .TNEW_W(2), .SRC_W(3)) sb ();

    hazard_scoreboard #(.STAGES(3), .TNEW_W(2), .SRC_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .sb(sb)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sb.issue_valid = 1'b0;
        sb.issue_we    = 1'b0;
        sb.issue_dst   = 5'd0;
        sb.issue_tnew  = 2'd0;
        sb.issue_src   = 3'd0;
        sb.rs          = 5'd0;
        sb.rt          = 5'd0;
        sb.tuse_rs     = TUSE_NONE;
        sb.tuse_rt     = TUSE_NONE;
        sb.hold        = 1'b0;
        sb.flush       = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic issue(input logic [4:0] dst, input logic [1:0] tnew, input logic [2:0] src);
        sb.issue_valid = 1'b1;
        sb.issue_we    = 1'b1;
        sb.issue_dst   = dst;
        sb.issue_tnew  = tnew;
        sb.issue_src   = src;
        tick();
        sb.issue_valid = 1'b0;
        sb.issue_we    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1;
        vectors++; if (sb.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", sb.stall); end
        vectors++; if (sb.fwd_sel_rs !== 2'd0 || sb.fwd_sel_rt !== 2'd0) begin errors++; $display("FAIL reset_fwd: got %0d/%0d expected 0/0", sb.fwd_sel_rs, sb.fwd_sel_rt); end
        vectors++; if (sb.slot_src !== 9'd0 || sb.slot_tnew !== 6'd0) begin errors++; $display("FAIL reset_slots: src %0h tnew %0h expected 0/0", sb.slot_src, sb.slot_tnew); end
        sb.hold = 1'b1;
        #1;
        vectors++; if (sb.stall !== 1'b1) begin errors++; $display("FAIL reset_hold_stall: got %0d expected 1", sb.stall); end
        sb.hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_forward();
        drain();
        issue(5'd8, 2'd1, SRC_ALU);
        sb.rs = 5'd8; sb.tuse_rs = 2'd1;
        #1;
        vectors++; if (sb.stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0d expected 0", sb.stall); end
        vectors++; if (sb.fwd_sel_rs !== 2'd0) begin errors++; $display("FAIL alu_fwd_early: got %0d expected 0", sb.fwd_sel_rs); end
        vectors++; if (sb.slot_tnew !== 6'b00_00_01) begin errors++; $display("FAIL alu_slot_tnew: got %0h expected 1", sb.slot_tnew); end
        tick();
        vectors++; if (sb.fwd_sel_rs !== 2'd2) begin errors++; $display("FAIL alu_fwd: got %0d expected 2", sb.fwd_sel_rs); end
    endtask

    task automatic test_load_use();
        drain();
        issue(5'd9, 2'd2, SRC_MEM);
        sb.rt = 5'd9; sb.tuse_rt = 2'd0;
        #1;
        vectors++; if (sb.slot_src !== 9'd1 || sb.slot_tnew !== 6'd2) begin errors++; $display("FAIL lw_slot0: src %0h tnew %0h expected 1/2", sb.slot_src, sb.slot_tnew); end
        vectors++; if (sb.stall !== 1'b1) begin errors++; $display("FAIL lw_stall_c1: got %0d expected 1", sb.stall); end
        tick();
        vectors++; if (sb.stall !== 1'b1 || sb.slot_tnew !== 6'd4) begin errors++; $display("FAIL lw_stall_c2: stall %0d tnew %0h expected 1/4", sb.stall, sb.slot_tnew); end
        tick();
        vectors++; if (sb.stall !== 1'b0) begin errors++; $display("FAIL lw_release: got %0d expected 0", sb.stall); end
        vectors++; if (sb.fwd_sel_rt !== 2'd3) begin errors++; $display("FAIL lw_fwd: got %0d expected 3", sb.fwd_sel_rt); end
        vectors++; if (sb.slot_src !== 9'd64) begin errors++; $display("FAIL lw_slot2_src: got %0h expected 40", sb.slot_src); end
    endtask

    task automatic test_zero_reg();
        drain();
        issue(5'd0, 2'd0, SRC_ALU);
        sb.rs = 5'd0; sb.tuse_rs = 2'd0;
        sb.rt = 5'd0; sb.tuse_rt = 2'd0;
        #1;
        vectors++; if (sb.stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %0d expected 0", sb.stall); end
        vectors++; if (sb.fwd_sel_rs !== 2'd0 || sb.fwd_sel_rt !== 2'd0) begin errors++; $display("FAIL zero_fwd: got %0d/%0d expected 0/0", sb.fwd_sel_rs, sb.fwd_sel_rt); end
    endtask

    task automatic test_youngest_wins();
        drain();
        issue(5'd5, 2'd0, SRC_ALU);
        issue(5'd5, 2'd2, SRC_MEM);
        sb.rs = 5'd5; sb.tuse_rs = 2'd1;
        #1;
        vectors++; if (sb.stall !== 1'b1) begin errors++; $display("FAIL young_stall: got %0d expected 1", sb.stall); end
        vectors++; if (sb.fwd_sel_rs !== 2'd0) begin errors++; $display("FAIL young_fwd: got %0d expected 0", sb.fwd_sel_rs); end
        sb.rs = 5'd0; sb.tuse_rs = TUSE_NONE;
        sb.rt = 5'd5; sb.tuse_rt = TUSE_NONE;
        #1;
        vectors++; if (sb.stall !== 1'b0 || sb.fwd_sel_rt !== 2'd0) begin errors++; $display("FAIL young_tuse_none: stall %0d fwd %0d expected 0/0", sb.stall, sb.fwd_sel_rt); end
    endtask

    task automatic test_hold();
        drain();
        issue(5'd7, 2'd2, SRC_ALU);
        sb.hold = 1'b1;
        sb.issue_valid = 1'b1; sb.issue_we = 1'b1; sb.issue_dst = 5'd10; sb.issue_tnew = 2'd1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++; if (sb.stall !== 1'b1 || sb.slot_tnew !== 6'd2) begin errors++; $display("FAIL hold_c%0d: stall %0d tnew %0h expected 1/2", c, sb.stall, sb.slot_tnew); end
            tick();
        end
        idle_inputs();
        #1;
        vectors++; if (sb.stall !== 1'b0 || sb.slot_tnew !== 6'd2) begin errors++; $display("FAIL hold_release: stall %0d tnew %0h expected 0/2", sb.stall, sb.slot_tnew); end
        tick();
        vectors++; if (sb.slot_tnew !== 6'd4) begin errors++; $display("FAIL hold_step1: got %0h expected 4", sb.slot_tnew); end
        tick();
        sb.rs = 5'd7;
        #1;
        vectors++; if (sb.slot_tnew !== 6'd0 || sb.fwd_sel_rs !== 2'd3) begin errors++; $display("FAIL hold_step2: tnew %0h fwd %0d expected 0/3", sb.slot_tnew, sb.fwd_sel_rs); end
    endtask

    task automatic test_flush();
        drain();
        issue(5'd11, 2'd2, SRC_ALU);
        issue(5'd12, 2'd2, SRC_ALU);
        issue(5'd13, 2'd2, SRC_ALU);
        sb.rs = 5'd11;
        #1;
        vectors++; if (sb.fwd_sel_rs !== 2'd3) begin errors++; $display("FAIL flush_pre: got %0d expected 3", sb.fwd_sel_rs); end
        sb.flush = 1'b1; sb.hold = 1'b1;
        sb.issue_valid = 1'b1; sb.issue_we = 1'b1; sb.issue_dst = 5'd14; sb.issue_tnew = 2'd2;
        tick();
        idle_inputs();
        sb.rs = 5'd13; sb.tuse_rs = 2'd0;
        sb.rt = 5'd14; sb.tuse_rt = 2'd0;
        #1;
        vectors++; if (sb.stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0d expected 0", sb.stall); end
        sb.rs = 5'd11; sb.rt = 5'd12;
        #1;
        vectors++; if (sb.fwd_sel_rs !== 2'd0 || sb.fwd_sel_rt !== 2'd0) begin errors++; $display("FAIL flush_fwd: got %0d/%0d expected 0/0", sb.fwd_sel_rs, sb.fwd_sel_rt); end
    endtask

    task automatic test_async_reset();
        drain();
        issue(5'd20, 2'd2, SRC_HILO);
        sb.rs = 5'd20; sb.tuse_rs = 2'd0;
        #1;
        vectors++; if (sb.stall !== 1'b1) begin errors++; $display("FAIL arst_pre: got %0d expected 1", sb.stall); end
        rst_n = 1'b0;
        #1;
        vectors++; if (sb.stall !== 1'b0 || sb.slot_tnew !== 6'd0 || sb.slot_src !== 9'd0) begin errors++; $display("FAIL arst_clear: stall %0d tnew %0h src %0h expected 0/0/0", sb.stall, sb.slot_tnew, sb.slot_src); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        tick();
        issue(5'd21, 2'd1, SRC_ALU);
        sb.rs = 5'd21; sb.tuse_rs = 2'd1;
        #1;
        vectors++; if (sb.stall !== 1'b0 || sb.slot_tnew !== 6'd1) begin errors++; $display("FAIL arst_after: stall %0d tnew %0h expected 0/1", sb.stall, sb.slot_tnew); end
    endtask

    initial begin
        test_reset();
        test_alu_forward();
        test_load_use();
        test_zero_reg();
        test_youngest_wins();
        test_hold();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
